// File: rtl/egm_pkg.sv
// rtl/egm_pkg.sv - shared state encoding, width default and saturating increment for egm_stimulus_gen
package egm_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } egm_state_t;

    // Widths up to 32 bits; callers zero-extend in and truncate out.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/egm_sync_edge.sv
// rtl/egm_sync_edge.sv - N-stage synchronizer with rising-edge detect on the last stage
module egm_sync_edge #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [N-1:0] sync_q, sync_d;
    logic         prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[N-2:0], din};
        prev_d = sync_q[N-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[N-1] & ~prev_q;

endmodule

// File: rtl/egm_stimulus_gen.sv
// rtl/egm_stimulus_gen.sv - periodic stimulus initiator with latency/miss measurement; EGM_SPURIOUS_CNT_EN adds spurious_count
module egm_stimulus_gen
    import egm_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] pulse_width,
    output logic             egm_stimulus,
    input  logic             egm_response,
    output logic [CNT_W-1:0] latency,
    output logic             latency_valid,
    output logic [CNT_W-1:0] pulse_count,
    output logic [CNT_W-1:0] missed_count,
`ifdef EGM_SPURIOUS_CNT_EN
    output logic [CNT_W-1:0] spurious_count,
`endif
    output logic             busy
);

    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ONES = '1;

    function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
        return CNT_W'(sat_inc(32'(v), 32'(ONES)));
    endfunction

    egm_state_t       state_q, state_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic             stim_q, stim_d;
    logic             out_q, out_d;
    logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [CNT_W-1:0] latency_q, latency_d;
    logic             lv_q, lv_d;
    logic [CNT_W-1:0] pulse_q, pulse_d;
    logic [CNT_W-1:0] miss_q, miss_d;
    logic [CNT_W-1:0] pw_c, low_c;
    logic             start, accept, resp_rise;

    egm_sync_edge #(.N(SYNC_STAGES)) u_sync (
        .clk  (clk_clk),
        .rst  (reset_reset),
        .din  (egm_response),
        .rise (resp_rise)
    );

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        low_d   = low_q;
        // Low time is stored instead of the period so pw = all-ones cannot overflow pw+1.
        pw_c    = (pulse_width == '0) ? ONE : pulse_width;
        low_c   = (period > pw_c) ? period - pw_c : ONE;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = HIGH;
                    tmr_d   = pw_c - ONE;
                    low_d   = low_c;
                end
            end
            HIGH: begin
                if (tmr_q == '0) begin
                    state_d = LOW;
                    tmr_d   = low_q - ONE;
                end else begin
                    tmr_d = tmr_q - ONE;
                end
            end
            LOW: begin
                if (tmr_q == '0) begin
                    if (enable) begin
                        state_d = HIGH;
                        tmr_d   = pw_c - ONE;
                        low_d   = low_c;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    tmr_d = tmr_q - ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        stim_d = (state_d == HIGH);
        start  = (state_d == HIGH) && (state_q != HIGH);
        // A response landing on the same edge as a new rise belongs to the old pulse.
        accept = resp_rise && out_q;

        pulse_d   = start ? inc(pulse_q) : pulse_q;
        miss_d    = (start && out_q && !accept) ? inc(miss_q) : miss_q;
        lat_cnt_d = start ? '0 : (out_q ? inc(lat_cnt_q) : lat_cnt_q);
        out_d     = start ? 1'b1 : (accept ? 1'b0 : out_q);
        latency_d = accept ? lat_cnt_q : latency_q;
        lv_d      = accept;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q   <= IDLE;
            tmr_q     <= '0;
            low_q     <= '0;
            stim_q    <= 1'b0;
            out_q     <= 1'b0;
            lat_cnt_q <= '0;
            latency_q <= '0;
            lv_q      <= 1'b0;
            pulse_q   <= '0;
            miss_q    <= '0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            low_q     <= low_d;
            stim_q    <= stim_d;
            out_q     <= out_d;
            lat_cnt_q <= lat_cnt_d;
            latency_q <= latency_d;
            lv_q      <= lv_d;
            pulse_q   <= pulse_d;
            miss_q    <= miss_d;
        end
    end

`ifdef EGM_SPURIOUS_CNT_EN
    logic [CNT_W-1:0] spur_q, spur_d;

    always_comb begin
        spur_d = (resp_rise && !out_q) ? inc(spur_q) : spur_q;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            spur_q <= '0;
        end else begin
            spur_q <= spur_d;
        end
    end

    assign spurious_count = spur_q;
`endif

    assign egm_stimulus  = stim_q;
    assign latency       = latency_q;
    assign latency_valid = lv_q;
    assign pulse_count   = pulse_q;
    assign missed_count  = miss_q;
    assign busy          = (state_q != IDLE);

endmodule
